// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

  // Loader session states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned BYTE_BITS   = 8;
  localparam int unsigned BIT_CNT_W   = 3;

endpackage

// File: rtl/prog_loader_sync_edge.sv
// sync_edge: multi-flop synchronizer for one async pin, with an optional
// registered rising-edge pulse.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   d          : async input pin
//   q          : synchronized level (SYNC_STAGES clk latency)
//   rise       : one-clk pulse per rising edge of q, one clk after q rises
//                (tied low when EDGE_EN = 0)
module sync_edge
  import prog_loader_pkg::*;
#(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Synchronizer chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      logic rise_q;

      // Registered edge detect: total pin-to-pulse latency is SYNC_STAGES+1
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          prev_q <= q;
          rise_q <= q & ~prev_q;
        end
      end

      assign rise = rise_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/prog_loader.sv
// prog_loader: bit-serial loader for the nibble processor's program memory.
// Receives MSB-first bytes on (load_en, sclk, sdata), writes them to
// sequential addresses from 0 and holds the core in reset while loading.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   load_en, sclk, sdata : async serial pins (session enable, bit clock, data)
//   wr_en/wr_addr/wr_data: one-clk program memory write strobe
//   cpu_hold             : holds the processor core in reset
//   byte_cnt             : bytes written in the current/last session
//   overflow             : sticky, more than DEPTH bytes seen in session
//   chksum               : mod-256 sum of written bytes
// Build option: LOADER_CHKSUM_EN enables the checksum accumulator; when
// undefined chksum is tied to zero.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              sclk,
  input  logic              sdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] byte_cnt,
  output logic              overflow,
  output logic [7:0]        chksum
);

  // One extra bit so the address can stop at DEPTH even when DEPTH == 2**ADDR_W
  localparam int unsigned AW1 = ADDR_W + 1;

  state_t                 state_q, next_state;
  logic                   load_s;
  logic                   sdata_s;
  logic                   sclk_rise;
  logic                   load_rise_unused;
  logic                   sdata_rise_unused;
  logic                   sclk_s_unused;
  logic [BYTE_BITS-1:0]   shreg_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [AW1-1:0]         addr_q;

  logic                   start_c;
  logic                   shift_c;
  logic                   capture_c;
  logic                   room_c;
  logic [BYTE_BITS-1:0]   byte_c;

  // Input conditioning
  sync_edge #(.EDGE_EN(1'b1)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sclk),
    .q     (sclk_s_unused),
    .rise  (sclk_rise)
  );

  sync_edge #(.EDGE_EN(1'b0)) u_sync_load (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (load_en),
    .q     (load_s),
    .rise  (load_rise_unused)
  );

  sync_edge #(.EDGE_EN(1'b0)) u_sync_sdata (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sdata),
    .q     (sdata_s),
    .rise  (sdata_rise_unused)
  );

  assign byte_c = {shreg_q[BYTE_BITS-2:0], sdata_s};
  assign room_c = addr_q < AW1'(DEPTH);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state and control decode
  always_comb begin
    next_state = state_q;
    start_c    = 1'b0;
    shift_c    = 1'b0;
    capture_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_s) begin
          next_state = SHIFT;
          start_c    = 1'b1;
        end
      end
      SHIFT: begin
        // Session end wins over a coincident bit; a partial byte is dropped
        if (!load_s) begin
          next_state = DONE;
        end else if (sclk_rise) begin
          shift_c = 1'b1;
          if (bit_cnt_q == BIT_CNT_W'(BYTE_BITS - 1)) begin
            next_state = WRITE;
            capture_c  = 1'b1;
          end
        end
      end
      WRITE: begin
        next_state = load_s ? SHIFT : DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b0;
      byte_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      cpu_hold <= (next_state != IDLE);

      if (start_c) begin
        addr_q    <= '0;
        bit_cnt_q <= '0;
        byte_cnt  <= '0;
        overflow  <= 1'b0;
      end

      if (shift_c) begin
        shreg_q   <= byte_c;
        bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
      end

      // Strobe is launched on the 8th-bit edge so it is visible in WRITE
      if (capture_c && room_c) begin
        wr_en   <= 1'b1;
        wr_addr <= addr_q[ADDR_W-1:0];
        wr_data <= byte_c;
      end

      // WRITE cycle: commit the strobe, or flag the dropped byte
      if (state_q == WRITE) begin
        if (wr_en) begin
          addr_q   <= addr_q + AW1'(1);
          byte_cnt <= byte_cnt + ADDR_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef LOADER_CHKSUM_EN
  logic [7:0] chksum_q;

  // Sum of strobed bytes; new value visible the cycle after wr_en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chksum_q <= '0;
    end else if (start_c) begin
      chksum_q <= '0;
    end else if (state_q == WRITE && wr_en) begin
      chksum_q <= chksum_q + wr_data;
    end
  end

  assign chksum = chksum_q;
`else
  assign chksum = 8'h00;
`endif

endmodule
